systolic_array_rxc: RTL and testbench

- Parametrised successor of the fixed 4x4 output-stationary systolic array: ROWS x COLS grid of MAC PEs with configurable operand and accumulator widths.
- Adds internal input skewing, per-job K-length control, ready/valid input flow control with bubbles, optional saturating accumulation, and a back-pressured row-by-row result drain FSM.
- Sits between the operand buffers and the NPU result writeback path; computes one C = A x B tile per job.

---
 rtl/systolic_array_rxc.sv | 219 +++++++++++++++++++++
 tb/tb_systolic_array_rxc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_rxc.sv
// Output-stationary ROWS x COLS MAC array with internal operand skew, per-job K length,
// ready/valid operand intake and a back-pressured row-by-row result drain.
module systolic_array_rxc #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned K_MAX      = 256,
    parameter int unsigned SATURATE   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    input  logic [ROWS*DATA_WIDTH-1:0]    a_vec,
    input  logic [COLS*DATA_WIDTH-1:0]    b_vec,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [COLS*ACC_WIDTH-1:0]     res_row,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_last,
    output logic                          busy,
    output logic                          done
);
    localparam int unsigned DW        = DATA_WIDTH;
    localparam int unsigned AW        = ACC_WIDTH;
    localparam int unsigned KW        = $clog2(K_MAX + 1);
    localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;
    localparam int unsigned FW        = $clog2(ROWS + COLS);
    localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
    logic [FW-1:0] fl_q, fl_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;
    logic          k_ok, accept, clr;

    assign k_ok   = (k_len != '0) && (k_len <= KW'(K_MAX));
    assign accept = in_valid && (state_q == StLoad);
    assign clr    = (state_q == StIdle) && start && k_ok;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && k_ok) begin
                    k_d     = k_len;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (cnt_q == k_q - 1'b1) begin
                        fl_d    = '0;
                        state_d = StFlush;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                if (fl_q == FW'(FLUSH_LEN - 1)) begin
                    row_d   = '0;
                    state_d = StDrain;
                end else begin
                    fl_d = fl_q + 1'b1;
                end
            end
            StDrain: begin
                if (res_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            cnt_q   <= '0;
            fl_q    <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign busy      = (state_q != StIdle);
    assign res_valid = (state_q == StDrain);
    assign res_last  = res_valid && (row_q == RW'(ROWS - 1));
    assign done      = done_q;

    // Lane words are {valid, data}; a non-accepted cycle injects a zero bubble.
    logic [DW:0]   a_lane [ROWS];
    logic [DW:0]   b_lane [COLS];
    logic [DW:0]   a_fwd  [ROWS][COLS];
    logic [DW:0]   b_fwd  [ROWS][COLS];
    logic [AW-1:0] acc_all [ROWS][COLS];

    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic [DW:0] head;
        assign head = accept ? {1'b1, a_vec[i*DW +: DW]} : '0;
        if (i == 0) begin : g_direct
            assign a_lane[i] = head;
        end else begin : g_delay
            logic [DW:0] sr_q [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= head;
                    for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign a_lane[i] = sr_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic [DW:0] head;
        assign head = accept ? {1'b1, b_vec[j*DW +: DW]} : '0;
        if (j == 0) begin : g_direct
            assign b_lane[j] = head;
        end else begin : g_delay
            logic [DW:0] sr_q [j];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < j; k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= head;
                    for (int k = 1; k < j; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign b_lane[j] = sr_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DW:0]            a_in, b_in, a_q, b_q;
            logic signed [2*DW-1:0] prod;
            logic [AW:0]            sum;
            logic [AW-1:0]          acc_q, acc_d;

            if (j == 0) begin : g_al
                assign a_in = a_lane[i];
            end else begin : g_ai
                assign a_in = a_fwd[i][j-1];
            end
            if (i == 0) begin : g_bl
                assign b_in = b_lane[j];
            end else begin : g_bi
                assign b_in = b_fwd[i-1][j];
            end

            assign prod = $signed(a_in[DW-1:0]) * $signed(b_in[DW-1:0]);
            // One guard bit exposes signed overflow as sum[AW] != sum[AW-1].
            assign sum  = {acc_q[AW-1], acc_q} + {{(AW + 1 - 2*DW){prod[2*DW-1]}}, prod};

            always_comb begin
                acc_d = acc_q;
                if (a_in[DW] && b_in[DW]) begin
                    if ((SATURATE != 0) && (sum[AW] != sum[AW-1])) begin
                        acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
                    end else begin
                        acc_d = sum[AW-1:0];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= clr ? '0 : acc_d;
                end
            end

            assign a_fwd[i][j]   = a_q;
            assign b_fwd[i][j]   = b_q;
            assign acc_all[i][j] = acc_q;
        end
    end

    always_comb begin
        res_row = '0;
        if (state_q == StDrain) begin
            for (int j = 0; j < COLS; j++) res_row[j*AW +: AW] = acc_all[row_q][j];
        end
    end
endmodule

// File: tb/tb_systolic_array_rxc.sv
// Directed bench for systolic_array_rxc: 4x4 identity jobs (clean, bubbles, back-pressure,
// after abort) against a scoreboard, plus 1x1 saturating and wrapping overflow instances.
module tb_systolic_array_rxc;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int KM = 256;
    localparam int KW = $clog2(KM + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, in_valid, in_ready, res_valid, res_ready, res_last, busy, done;
    logic [KW-1:0]   k_len;
    logic [R*DW-1:0] a_vec;
    logic [C*DW-1:0] b_vec;
    logic [C*AW-1:0] res_row;

    logic            o_start, o_valid, o_rready;
    logic [KW-1:0]   o_k;
    logic [DW-1:0]   o_a, o_b;
    logic            s_iready, s_valid, s_last, s_busy, s_done;
    logic            w_iready, w_valid, w_last, w_busy, w_done;
    logic [AW-1:0]   s_row, w_row;

    systolic_array_rxc #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM),
                         .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .a_vec(a_vec), .b_vec(b_vec),
        .in_valid(in_valid), .in_ready(in_ready), .res_row(res_row), .res_valid(res_valid),
        .res_ready(res_ready), .res_last(res_last), .busy(busy), .done(done)
    );

    systolic_array_rxc #(.ROWS(1), .COLS(1), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM),
                         .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(o_start), .k_len(o_k), .a_vec(o_a), .b_vec(o_b),
        .in_valid(o_valid), .in_ready(s_iready), .res_row(s_row), .res_valid(s_valid),
        .res_ready(o_rready), .res_last(s_last), .busy(s_busy), .done(s_done)
    );

    systolic_array_rxc #(.ROWS(1), .COLS(1), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM),
                         .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(o_start), .k_len(o_k), .a_vec(o_a), .b_vec(o_b),
        .in_valid(o_valid), .in_ready(w_iready), .res_row(w_row), .res_valid(w_valid),
        .res_ready(o_rready), .res_last(w_last), .busy(w_busy), .done(w_done)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [C*AW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [C*AW-1:0] obs, input logic [C*AW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // C = I4 x B with B[k][j] = 4k+j+1.
    task automatic push_identity_expect();
        for (int r = 0; r < R; r++) begin
            logic [C*AW-1:0] v;
            v = '0;
            for (int j = 0; j < C; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 4; k++) s += ((r == k) ? 1 : 0) * (4*k + j + 1);
                v[j*AW +: AW] = s;
            end
            exp_q.push_back(v);
        end
    endtask

    task automatic drive_beat(input bit drive, input int idx);
        in_valid = drive;
        for (int i = 0; i < R; i++) a_vec[i*DW +: DW] = (drive && i == idx) ? 16'd1 : 16'd0;
        for (int j = 0; j < C; j++) b_vec[j*DW +: DW] = drive ? DW'(4*idx + j + 1) : '0;
    endtask

    task automatic run_job(input string nm, input bit bubble, input int hold_row,
                           input int hold_n);
        int sent, rows, held, last_acc, first_v;
        bit got_done, drive;
        logic [C*AW-1:0] hold_val;
        sent = 0; rows = 0; held = 0; last_acc = -1; first_v = -1; got_done = 0;
        hold_val = '0;
        push_identity_expect();
        start = 1'b1; k_len = 4;
        step();
        start = 1'b0;
        for (int t = 0; t < 100 && !got_done; t++) begin
            drive = (sent < 4) && (!bubble || (t % 2 == 0));
            drive_beat(drive, sent);
            res_ready = 1'b1;
            if (res_valid && rows == hold_row && held < hold_n) begin
                res_ready = 1'b0;
                if (held == 0) hold_val = res_row;
                else chk({nm, " held row stable"}, res_row, hold_val);
                held++;
            end
            if (sent < 4) chk({nm, " in_ready during load"}, in_ready, 1);
            if (last_acc >= 0 && cyc == last_acc + 1) chk({nm, " in_ready drop"}, in_ready, 0);
            if (res_valid && first_v < 0) begin
                first_v = cyc;
                chk({nm, " first result latency"}, cyc - last_acc, 8);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) chk({nm, " unexpected row"}, rows, -1);
                else chk({nm, " row"}, res_row, exp_q.pop_front());
                chk({nm, " res_last"}, res_last, (rows == R - 1) ? 1 : 0);
                rows++;
            end
            if (done) begin
                got_done = 1;
                chk({nm, " rows before done"}, rows, R);
                chk({nm, " res_valid at done"}, res_valid, 0);
                chk({nm, " busy at done"}, busy, 0);
            end
            if (drive && in_ready) begin
                sent++;
                if (sent == 4) last_acc = cyc;
            end
            step();
        end
        drive_beat(1'b0, 0);
        chk({nm, " done seen"}, got_done, 1);
        chk({nm, " done one cycle"}, done, 0);
    endtask

    initial begin
        bit saw;
        rst = 1'b1; start = 1'b0; k_len = '0; a_vec = '0; b_vec = '0; in_valid = 1'b0;
        res_ready = 1'b1;
        o_start = 1'b0; o_k = '0; o_a = '0; o_b = '0; o_valid = 1'b0; o_rready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset in_ready", in_ready, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset res_row", res_row, 0);
        chk("reset res_last", res_last, 0);

        start = 1'b1; k_len = 0;
        step();
        chk("k_len=0 ignored", busy, 0);
        k_len = 300;
        step();
        start = 1'b0;
        chk("k_len>K_MAX ignored", busy, 0);
        chk("ignored start no done", done, 0);

        run_job("identity", 1'b0, -1, 0);
        run_job("bubbles", 1'b1, -1, 0);
        run_job("backpressure", 1'b0, 1, 3);

        // Abort after two accepted beats.
        start = 1'b1; k_len = 4;
        step();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            drive_beat(1'b1, b);
            step();
        end
        drive_beat(1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", busy, 0);
        saw = 0;
        for (int t = 0; t < 12; t++) begin
            if (done || res_valid) saw = 1;
            step();
        end
        chk("abort produced no output", saw, 0);
        run_job("after abort", 1'b0, -1, 0);
        chk("scoreboard empty", exp_q.size(), 0);

        // Overflow: three beats of (-32768)*(-32768) = 2^30 on 1x1 arrays.
        o_start = 1'b1; o_k = 3;
        step();
        o_start = 1'b0;
        o_a = 16'h8000; o_b = 16'h8000; o_valid = 1'b1;
        repeat (3) step();
        o_valid = 1'b0;
        saw = 0;
        for (int t = 0; t < 20 && !saw; t++) begin
            if (s_valid) begin
                saw = 1;
                chk("saturate result", s_row, 32'h7FFF_FFFF);
                chk("wrap result", w_row, 32'hC000_0000);
                chk("1x1 res_last", s_last, 1);
                chk("wrap res_valid aligned", w_valid, 1);
            end
            step();
        end
        chk("overflow result seen", saw, 1);
        chk("saturate done", s_done, 1);
        chk("wrap done", w_done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
